// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage feeding the single-cycle controller.
// Holds the PC, fetches one 32-bit word per request over a MIO_ready
// handshake, latches it into the instruction register and advances the PC
// (sequential or redirect) when the consumer acknowledges the word.
// Optional feature macro: IFETCH_TIMEOUT_EN adds a memory wait timeout that
// parks the unit in S_ERR with fetch_err set until reset.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        MIO_ready,
    output logic [31:0] inst,
    output logic [5:0]  OPcode,
    output logic [5:0]  Fun,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    input  logic        inst_ack,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] pc_out_r, pc_out_s;
    logic [31:0] redirect_target_s;
    logic        timeout_s;
    logic        unused_rpc_s;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign redirect_target_s = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_s      = ^redirect_pc[1:0];

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    logic [7:0] wait_cnt_r, wait_cnt_s;

    // The wait that would bring the counter up to TIMEOUT_CYCLES is the fatal one.
    assign timeout_s = (wait_cnt_r == WAIT_LAST);

    // Wait counter: counts unanswered request cycles, clears on any other outcome.
    always_comb begin
        wait_cnt_s = 8'd0;
        if ((state_r == S_REQ) && !redirect && !MIO_ready && !timeout_s) begin
            wait_cnt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_s = 8'd0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_s;
        end
    end
`else
    logic unused_timeout_s;

    // Without the timeout the unit waits on memory indefinitely.
    assign timeout_s        = 1'b0;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        inst_s   = inst_r;
        pc_out_s = pc_out_r;
        case (state_r)
            S_REQ: begin
                if (redirect) begin
                    // Redirect wins: any word arriving this cycle is dropped.
                    pc_s    = redirect_target_s;
                    state_s = S_REQ;
                end else if (MIO_ready) begin
                    inst_s   = imem_data;
                    pc_out_s = pc_r;
                    state_s  = S_VALID;
                end else if (timeout_s) begin
                    state_s = S_ERR;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_VALID: begin
                if (inst_ack) begin
                    if (redirect) begin
                        pc_s = redirect_target_s;
                    end else begin
                        pc_s = pc_r + 32'd4;
                    end
                    state_s = S_REQ;
                end else begin
                    state_s = S_VALID;
                end
            end
            S_ERR: begin
                state_s = S_ERR;
            end
            default: begin
                state_s = S_REQ;
            end
        endcase
    end

    // State, PC and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_REQ;
            pc_r     <= RESET_PC;
            inst_r   <= 32'h0000_0000;
            pc_out_r <= RESET_PC;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            inst_r   <= inst_s;
            pc_out_r <= pc_out_s;
        end
    end

    // Outputs come only from registers; rst_n gates the request during reset.
    assign imem_req   = rst_n & (state_r == S_REQ);
    assign imem_addr  = pc_r;
    assign inst       = inst_r;
    assign OPcode     = inst_r[31:26];
    assign Fun        = inst_r[5:0];
    assign pc_out     = pc_out_r;
    assign pc_plus4   = pc_out_r + 32'd4;
    assign inst_valid = (state_r == S_VALID);
`ifdef IFETCH_TIMEOUT_EN
    assign fetch_err  = (state_r == S_ERR);
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: two instances (RESET_PC 0 and 32'hFFFF_FFFC),
// a behavioural fetch model checked every cycle, plus directed literal checks.
module tb_ifetch_unit;

    localparam int TO = 4;
`ifdef IFETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_v, rdy_v, ack_v, redir_v;
    logic [1:0][31:0] data_v, rpc_v;
    logic [1:0]       req_v, valid_v, err_v;
    logic [1:0][31:0] addr_v, inst_v, pcout_v, pcp4_v;
    logic [1:0][5:0]  op_v, fun_v;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TO)) u0 (
        .clk(clk), .rst_n(rst_v[0]), .imem_req(req_v[0]), .imem_addr(addr_v[0]),
        .imem_data(data_v[0]), .MIO_ready(rdy_v[0]), .inst(inst_v[0]), .OPcode(op_v[0]),
        .Fun(fun_v[0]), .pc_out(pcout_v[0]), .pc_plus4(pcp4_v[0]), .inst_valid(valid_v[0]),
        .inst_ack(ack_v[0]), .redirect(redir_v[0]), .redirect_pc(rpc_v[0]), .fetch_err(err_v[0])
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(TO)) u1 (
        .clk(clk), .rst_n(rst_v[1]), .imem_req(req_v[1]), .imem_addr(addr_v[1]),
        .imem_data(data_v[1]), .MIO_ready(rdy_v[1]), .inst(inst_v[1]), .OPcode(op_v[1]),
        .Fun(fun_v[1]), .pc_out(pcout_v[1]), .pc_plus4(pcp4_v[1]), .inst_valid(valid_v[1]),
        .inst_ack(ack_v[1]), .redirect(redir_v[1]), .redirect_pc(rpc_v[1]), .fetch_err(err_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] start_pc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    // Behavioural model: "holding" a fetched word or "waiting" for memory.
    logic [1:0]       m_hold, m_dead;
    logic [1:0][31:0] m_pc, m_inst, m_pcout;
    int               m_wait [2];

    // Model update at each rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_v[i]) begin
                m_hold[i] <= 1'b0; m_dead[i] <= 1'b0; m_wait[i] <= 0;
                m_pc[i] <= start_pc(i); m_pcout[i] <= start_pc(i); m_inst[i] <= 32'h0;
            end else if (m_dead[i]) begin
                m_dead[i] <= 1'b1;
            end else if (!m_hold[i]) begin
                if (redir_v[i]) begin
                    m_pc[i] <= rpc_v[i] & 32'hFFFF_FFFC;
                    m_wait[i] <= 0;
                end else if (rdy_v[i]) begin
                    m_inst[i] <= data_v[i]; m_pcout[i] <= m_pc[i];
                    m_hold[i] <= 1'b1; m_wait[i] <= 0;
                end else if (TO_EN) begin
                    if (m_wait[i] + 1 >= TO) m_dead[i] <= 1'b1;
                    m_wait[i] <= m_wait[i] + 1;
                end
            end else if (ack_v[i]) begin
                m_pc[i] <= redir_v[i] ? (rpc_v[i] & 32'hFFFF_FFFC) : m_pc[i] + 32'd4;
                m_hold[i] <= 1'b0;
            end
        end
    end

    // Per-cycle compare of every output of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        e_req, e_valid, e_err;
            logic [31:0] e_addr, e_inst, e_pcout;
            if (!rst_v[i]) begin
                e_req = 1'b0; e_valid = 1'b0; e_err = 1'b0;
                e_addr = start_pc(i); e_inst = 32'h0; e_pcout = start_pc(i);
            end else begin
                e_req = !m_hold[i] && !m_dead[i]; e_valid = m_hold[i] && !m_dead[i];
                e_err = m_dead[i]; e_addr = m_pc[i]; e_inst = m_inst[i]; e_pcout = m_pcout[i];
            end
            chk($sformatf("u%0d.imem_req", i),   req_v[i],   e_req);
            chk($sformatf("u%0d.imem_addr", i),  addr_v[i],  e_addr);
            chk($sformatf("u%0d.inst", i),       inst_v[i],  e_inst);
            chk($sformatf("u%0d.OPcode", i),     op_v[i],    e_inst >> 26);
            chk($sformatf("u%0d.Fun", i),        fun_v[i],   e_inst & 32'h3F);
            chk($sformatf("u%0d.pc_out", i),     pcout_v[i], e_pcout);
            chk($sformatf("u%0d.pc_plus4", i),   pcp4_v[i],  e_pcout + 32'd4);
            chk($sformatf("u%0d.inst_valid", i), valid_v[i], e_valid);
            chk($sformatf("u%0d.fetch_err", i),  err_v[i],   e_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_v = 2'b00; rdy_v = 2'b00; ack_v = 2'b00; redir_v = 2'b00;
        data_v = '0; rpc_v = '0;
        repeat (3) cyc();

        // Reset release
        @(posedge clk); #2 rst_v[0] = 1'b1;
        @(negedge clk);
        chk("rst_req", req_v[0], 32'd1);
        chk("rst_addr", addr_v[0], 32'h0);
        chk("rst_valid", valid_v[0], 32'd0);
        chk("rst_inst", inst_v[0], 32'h0);

        // Back-to-back fetch of an add at address 0
        rdy_v[0] = 1'b1; data_v[0] = 32'h0000_0020; ack_v[0] = 1'b1;
        cyc();
        chk("b2b_valid", valid_v[0], 32'd1);
        chk("b2b_opcode", op_v[0], 32'h0);
        chk("b2b_fun", fun_v[0], 32'h20);
        cyc();
        chk("b2b_next_addr", addr_v[0], 32'h4);

        // Stall with redirect pulsed while the word is held
        data_v[0] = 32'h8C22_0008; ack_v[0] = 1'b0;
        cyc();
        rdy_v[0] = 1'b0; rpc_v[0] = 32'h0000_0200;
        for (int k = 0; k < 5; k++) begin
            redir_v[0] = (k == 2);
            cyc();
            chk("stall_inst", inst_v[0], 32'h8C22_0008);
            chk("stall_pc_out", pcout_v[0], 32'h4);
            chk("stall_valid", valid_v[0], 32'd1);
            chk("stall_req", req_v[0], 32'd0);
        end
        redir_v[0] = 1'b0; ack_v[0] = 1'b1;
        cyc();
        chk("stall_next_addr", addr_v[0], 32'h8);

        // Redirect with ack, then a redirect racing a memory response
        ack_v[0] = 1'b0; rdy_v[0] = 1'b1; data_v[0] = 32'h03E0_0008;
        cyc();
        ack_v[0] = 1'b1; redir_v[0] = 1'b1; rpc_v[0] = 32'h0000_0103; rdy_v[0] = 1'b0;
        cyc();
        chk("redir_addr", addr_v[0], 32'h100);
        ack_v[0] = 1'b0; rpc_v[0] = 32'h0000_0040; rdy_v[0] = 1'b1; data_v[0] = 32'hDEAD_BEEF;
        cyc();
        chk("redir_drop_valid", valid_v[0], 32'd0);
        chk("redir_drop_addr", addr_v[0], 32'h40);
        redir_v[0] = 1'b0; data_v[0] = 32'h2002_0005;
        cyc();
        chk("redir_fetch_inst", inst_v[0], 32'h2002_0005);
        chk("redir_fetch_pc", pcout_v[0], 32'h40);
        chk("redir_fetch_op", op_v[0], 32'h08);

        // Reset asserted mid-hold
        @(posedge clk); #2 rst_v[0] = 1'b0;
        #1;
        chk("midrst_valid", valid_v[0], 32'd0);
        chk("midrst_inst", inst_v[0], 32'h0);
        chk("midrst_req", req_v[0], 32'd0);
        @(negedge clk);

        // Memory never answers
        rdy_v[0] = 1'b0; ack_v[0] = 1'b0;
        @(posedge clk); #2 rst_v[0] = 1'b1;
        repeat (3) cyc();
        chk("to_early_err", err_v[0], 32'd0);
        cyc();
        chk("to_err", err_v[0], TO_EN ? 32'd1 : 32'd0);
        chk("to_req", req_v[0], TO_EN ? 32'd0 : 32'd1);
        repeat (3) cyc();
        chk("to_err_hold", err_v[0], TO_EN ? 32'd1 : 32'd0);
        @(posedge clk); #2 rst_v[0] = 1'b0;
        @(negedge clk);
        chk("to_rst_clear", err_v[0], 32'd0);

        // PC wrap on the second instance
        @(posedge clk); #2 rst_v[1] = 1'b1;
        rdy_v[1] = 1'b1; data_v[1] = 32'h0000_0020; ack_v[1] = 1'b0;
        cyc();
        chk("wrap_pc_out", pcout_v[1], 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pcp4_v[1], 32'h0);
        ack_v[1] = 1'b1; rdy_v[1] = 1'b0;
        cyc();
        chk("wrap_addr", addr_v[1], 32'h0);
        chk("wrap_req", req_v[1], 32'd1);
        ack_v[1] = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
